// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word, RAM status and arbiter state types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - serve-state cycle counter that flags a hung RAM transaction
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [9:0] wd_cnt_q, wd_cnt_d;

  assign expired = (wd_cnt_q == 10'(TIMEOUT - 1));

  // Holds at the expiry value so a stalled arbiter cannot wrap back to "fresh".
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (clear) begin
      wd_cnt_d = '0;
    end else if (count_en && !expired) begin
      wd_cnt_d = wd_cnt_q + 10'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - single-port RAM arbiter between instruction fetch and data access
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        bus_err
);

  arb_state_t state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       bus_err_q, bus_err_d;
  logic       dreq, starve_full, wd_expired, wd_clear, wd_count;
  ramstate_t  rs;

  assign rs          = ramstate_t'(ramstate);
  assign dreq        = dREN | dWEN;
  assign starve_full = (starve_cnt_q == 4'(STARVE_LIMIT));
  assign wd_clear    = (state_q == IDLE);
  assign wd_count    = (state_q != IDLE) && (rs != ACCESS);
  assign bus_err     = bus_err_q;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .CLK      (CLK),
    .nRST     (nRST),
    .clear    (wd_clear),
    .count_en (wd_count),
    .expired  (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    bus_err_d    = bus_err_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = iREN;
    dwait        = dreq;
    iload        = '0;
    dload        = '0;

    case (state_q)
      IDLE: begin
        if (iREN && (!dreq || starve_full)) begin
          state_d      = SERVE_I;
          starve_cnt_d = '0;
        end else if (dreq) begin
          state_d = SERVE_D;
          if (!iREN) begin
            starve_cnt_d = '0;
          end else if (!starve_full) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (!iREN) begin
          starve_cnt_d = '0;
        end
      end

      SERVE_I: begin
        // A dropped request (pipeline flush) abandons the access with no load.
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (rs == ACCESS) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end else if (rs == ERROR || wd_expired) begin
            iwait     = 1'b0;
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      SERVE_D: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (rs == ACCESS) begin
            dwait   = 1'b0;
            dload   = dWEN ? 32'h0 : ramload;
            state_d = IDLE;
          end else if (rs == ERROR || wd_expired) begin
            dwait     = 1'b0;
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      bus_err_q    <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - randomized and directed checks of memory_arbiter against a transaction model
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int SL = 4;
  localparam int TO = 8;

  logic        CLK, nRST, iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        ramREN, ramWEN, iwait, dwait, bus_err;
  logic [31:0] ramaddr, ramstore, iload, dload;

  int total = 0;
  int bad   = 0;
  int cyc;

  // model: owner 0 = nobody, 1 = instruction, 2 = data; age = serve cycles so far
  int   m_owner, m_age, m_starve, m_owner_n, m_age_n, m_starve_n;
  logic m_err, m_err_n;
  bit   prev_i_done, prev_d_done;

  bit rand_mode, i_repeat, d_repeat, fixed_load;
  int ram_lat, i_drop_at, d_kind;
  int first_ilow, first_dlow, dcount;

  memory_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .bus_err(bus_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic set_d(input int kind);
    dWEN = (kind != 0);
    dREN = (kind != 1);
  endtask

  task automatic rand_d_req();
    int k;
    k = $urandom % 8;
    set_d(k < 2 ? 1 : (k == 2 ? 2 : 0));
    daddr  = $urandom;
    dstore = $urandom;
  endtask

  task automatic drive();
    int r;
    ramload = fixed_load ? 32'h3C010004 : $urandom;
    if (rand_mode) begin
      if (!iREN) begin
        if ($urandom % 2 == 0) begin iREN = 1'b1; iaddr = $urandom; end
      end else if (prev_i_done) begin
        iREN = ($urandom % 3 == 0); iaddr = $urandom;
      end else if ($urandom % 25 == 0) begin
        iREN = 1'b0;
      end
      if (!(dREN || dWEN)) begin
        if ($urandom % 2 == 0) rand_d_req();
      end else if (prev_d_done) begin
        if ($urandom % 3 == 0) rand_d_req(); else begin dREN = 1'b0; dWEN = 1'b0; end
      end else if ($urandom % 25 == 0) begin
        dREN = 1'b0; dWEN = 1'b0;
      end
      r = $urandom % 100;
      ramstate = (r < 30) ? ACCESS : (r < 31) ? ERROR : (r < 65) ? BUSY : FREE;
    end else begin
      if (prev_i_done) begin iREN = i_repeat; iaddr = iaddr + 32'd4; end
      if (prev_d_done) begin
        if (d_repeat) set_d(d_kind); else begin dREN = 1'b0; dWEN = 1'b0; end
        daddr = daddr + 32'd4;
      end
      if (i_drop_at >= 0 && m_owner == 1 && m_age == i_drop_at) iREN = 1'b0;
      ramstate = (m_owner != 0 && m_age == ram_lat - 1) ? ACCESS : BUSY;
    end
  endtask

  task automatic eval_check();
    logic        dq, e_ren, e_wen, e_iw, e_dw, fin, fault;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    dq = dREN | dWEN;
    e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
    e_iw = iREN; e_dw = dq; fin = 0;
    prev_i_done = 0; prev_d_done = 0;
    m_owner_n = m_owner; m_age_n = m_age + 1; m_starve_n = m_starve; m_err_n = m_err;
    fault = (ramstate == ERROR) || (m_age == TO - 1);
    if (m_owner == 0) begin
      m_age_n = 0;
      if (iREN && (!dq || m_starve == SL)) begin
        m_owner_n = 1; m_starve_n = 0;
      end else if (dq) begin
        m_owner_n  = 2;
        m_starve_n = iREN ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
      end else if (!iREN) begin
        m_starve_n = 0;
      end
    end else if (m_owner == 1) begin
      if (!iREN) fin = 1;
      else begin
        e_ren = 1; e_addr = iaddr;
        if (ramstate == ACCESS) begin e_iw = 0; e_il = ramload; fin = 1; prev_i_done = 1; end
        else if (fault) begin e_iw = 0; m_err_n = 1; fin = 1; prev_i_done = 1; end
      end
    end else begin
      if (!dq) fin = 1;
      else begin
        e_addr = daddr;
        if (dWEN) begin e_wen = 1; e_store = dstore; end else e_ren = 1;
        if (ramstate == ACCESS) begin
          e_dw = 0; e_dl = dWEN ? 32'h0 : ramload; fin = 1; prev_d_done = 1;
        end else if (fault) begin e_dw = 0; m_err_n = 1; fin = 1; prev_d_done = 1; end
      end
    end
    if (fin) m_owner_n = 0;

    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("iwait", iwait, e_iw);
    chk("dwait", dwait, e_dw);
    chk("iload", iload, e_il);
    chk("dload", dload, e_dl);
    chk("bus_err", bus_err, m_err);

    if (dq && dwait === 1'b0 && first_ilow < 0) dcount++;
    if (dq && dwait === 1'b0 && first_dlow < 0) first_dlow = cyc;
    if (iREN && iwait === 1'b0 && first_ilow < 0) first_ilow = cyc;
  endtask

  task automatic tick();
    drive();
    @(negedge CLK);
    eval_check();
    @(posedge CLK);
    m_owner = m_owner_n; m_age = m_age_n; m_starve = m_starve_n; m_err = m_err_n;
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    m_owner = 0; m_age = 0; m_starve = 0; m_err = 1'b0;
    iREN = 1'($urandom); dREN = 1'($urandom); dWEN = 1'($urandom);
    #1;
    eval_check();
    prev_i_done = 0; prev_d_done = 0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic start_scn();
    do_reset();
    cyc = 0; first_ilow = -1; first_dlow = -1; dcount = 0;
    rand_mode = 0; i_repeat = 0; d_repeat = 0; fixed_load = 0;
    ram_lat = 1; i_drop_at = -1; d_kind = 0;
  endtask

  initial begin
    nRST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
    #2;

    // fetch completes on the first serve cycle
    start_scn();
    fixed_load = 1; iREN = 1; iaddr = 32'h0;
    repeat (4) tick();
    chk("fetch_lat", 32'(first_ilow), 32'd1);

    // simultaneous fetch and store: data first, 2-cycle RAM
    start_scn();
    ram_lat = 2; iREN = 1; iaddr = 32'h40;
    d_kind = 1; set_d(1); daddr = 32'h80; dstore = 32'hDEADBEEF;
    repeat (8) tick();
    chk("store_lat", 32'(first_dlow), 32'd2);
    chk("fetch_after_store", 32'(first_ilow), 32'd5);

    // continuous data traffic: fetch wins after SL data grants
    start_scn();
    iREN = 1; i_repeat = 1; d_repeat = 1; d_kind = 0; set_d(0); daddr = 32'h200;
    repeat (20) tick();
    chk("starve_grants", 32'(dcount), 32'(SL));
    chk("starve_fetch_lat", 32'(first_ilow), 32'(2 * SL + 1));

    // read+write together performs a write
    start_scn();
    d_kind = 2; set_d(2); daddr = 32'h100; dstore = 32'h12345678;
    repeat (4) tick();

    // fetch flushed while RAM busy
    start_scn();
    ram_lat = 1000; i_drop_at = 1; iREN = 1; iaddr = 32'h300;
    repeat (5) tick();
    chk("abort_no_err", bus_err, 1'b0);

    // hung RAM: watchdog aborts, sticky error, async reset clears
    start_scn();
    ram_lat = 1000; d_kind = 0; set_d(0); daddr = 32'h400;
    repeat (12) tick();
    chk("timeout_lat", 32'(first_dlow), 32'(TO));
    chk("err_sticky", bus_err, 1'b1);
    start_scn();
    chk("err_cleared", bus_err, 1'b0);

    // randomized traffic with occasional mid-transaction resets
    start_scn();
    rand_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 150 == 0) do_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch path and the data path (LW/SW from control_unit's memREN/memWEN) of the MIPS core.
- Sequences one RAM transaction at a time with a registered grant FSM.
- Default priority is data over instruction, with a starvation limiter so fetch always makes progress.
- A watchdog terminates hung RAM transactions and raises a sticky bus error.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants made while iREN is pending before instruction is forced to win (range 1..15).
- TIMEOUT, 255: maximum cycles in a serve state without ramstate==ACCESS before abort (range 1..1023).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  32 (word_t)  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32 (word_t)  data address.
- dstore  in  32 (word_t)  write data.
- ramstate  in  2 (ramstate_t)  RAM status: FREE, BUSY, ACCESS, ERROR.
- ramload  in  32 (word_t)  RAM read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- iwait  out  1  instruction not yet complete.
- dwait  out  1  data not yet complete.
- iload  out  32  instruction read data.
- dload  out  32  data read data.
- bus_err  out  1  sticky error flag.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is nRST, asynchronous and active-low. Reset puts the FSM in IDLE, clears starve_cnt, wd_cnt and bus_err.
- Outputs in IDLE and during reset:
  - ramREN=ramWEN=0; ramaddr=ramstore=0; iload=dload=0.
  - iwait=iREN; dwait=dREN|dWEN.
- FSM states: IDLE, SERVE_I, SERVE_D (enum arb_state_t).
- IDLE arbitration, evaluated at the clock edge:
  - dreq=dREN|dWEN.
  - If iREN && (!dreq || starve_cnt==STARVE_LIMIT), go to SERVE_I.
  - Else if dreq, go to SERVE_D.
  - Else stay in IDLE.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each SERVE_D grant while iREN=1.
  - Clears on a SERVE_I grant, or in any IDLE cycle with iREN=0.
- Serve drive (combinational from state and live requester inputs; requesters hold addr/data stable while their wait is high):
  - SERVE_I: ramREN=1, ramaddr=iaddr.
  - SERVE_D: ramaddr=daddr. If dWEN, ramWEN=1, ramREN=0, ramstore=dstore (write wins when dREN&dWEN). Otherwise ramREN=1.
- Completion:
  - When ramstate==ACCESS in the serve state, the served wait is 0 that same cycle and its load=ramload (dload=0 on a write). Next state is IDLE.
  - The other requester's wait stays 1 throughout.
- Latency: minimum 2 cycles from request to wait low (1 grant cycle plus 1 ACCESS cycle). A back-to-back request from the same requester re-arbitrates through IDLE.
- Abort:
  - If the served request drops (e.g. the requester flushes) before ACCESS, ram enables drop combinationally and next state is IDLE. No load is returned.
  - A data abort does not touch starve_cnt.
- Watchdog:
  - wd_cnt clears on entry to a serve state and increments each serve cycle without ACCESS.
  - When wd_cnt==TIMEOUT-1, or ramstate==ERROR: the served wait goes to 0 with load=32'h0, bus_err is set, and next state is IDLE.
  - bus_err stays 1 until reset.
- Reset mid-transaction: outputs go to their reset values immediately (asynchronous). The RAM transaction is abandoned; the RAM model must tolerate a dropped enable.
- ramstate FREE or BUSY in a serve state means keep waiting.

Decomposition:
- cpu_types_pkg: reuse word_t and ramstate_t; add arb_state_t {IDLE, SERVE_I, SERVE_D}.
- Sub-module mem_arb_watchdog (clear, count-enable, TIMEOUT parameter, expired output) holds wd_cnt.
- Arbitration and the starvation counter stay in memory_arbiter.

Test Plan:
- Reset with iREN=1, iaddr=0x0, RAM ACCESS on 1st serve cycle, ramload=0x3C010004 -> ramREN=1, ramaddr=0 in cycle 1; iwait=0, iload=0x3C010004 in cycle 1; back to IDLE.
- iREN=1 and dWEN=1 both at cycle 0, daddr=0x80, dstore=0xDEADBEEF, RAM 2-cycle latency -> SERVE_D first, ramWEN=1, ramstore=0xDEADBEEF; dwait low at cycle 2; SERVE_I follows; iwait low at cycle 5.
- iREN held, dREN reasserted continuously, STARVE_LIMIT=4 -> exactly 4 data grants, then SERVE_I; starve_cnt back to 0.
- dREN=dWEN=1, daddr=0x100 -> write performed, ramREN=0, dload=0.
- iREN dropped at cycle 2 of SERVE_I with ramstate=BUSY -> ramREN=0 that cycle; IDLE next; iwait=0; bus_err=0.
- ramstate stuck BUSY, TIMEOUT=8 -> dwait low on the 8th serve cycle, dload=0, bus_err=1 and held; nRST low clears it asynchronously.
